// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS-subset sequencer: FSM state codes,
// opcode/func values, ALU control encodings, pc_src selects and decode classes.
package mc_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_WB_R     = 4'd3;
  localparam logic [3:0] ST_EXEC_I   = 4'd4;
  localparam logic [3:0] ST_WB_I     = 4'd5;
  localparam logic [3:0] ST_MEM_ADDR = 4'd6;
  localparam logic [3:0] ST_MEM_RD   = 4'd7;
  localparam logic [3:0] ST_WB_MEM   = 4'd8;
  localparam logic [3:0] ST_MEM_WR   = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;
  localparam logic [3:0] ST_TRAP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ILL
  } mc_cls_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/func to an execution class,
// the ALU operation and immediate extension mode, and flags illegal encodings.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output mc_cls_e    cls,
  output logic [3:0] aluop,
  output logic       extop,
  output logic       legal
);

  always_comb begin
    cls   = CLS_ILL;
    aluop = ALU_AND;
    extop = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: cls   = CLS_ILL;
        endcase
      end
      OP_LW:   begin cls = CLS_LW;  aluop = ALU_ADD; extop = 1'b1; end
      OP_SW:   begin cls = CLS_SW;  aluop = ALU_ADD; extop = 1'b1; end
      OP_BEQ:  begin cls = CLS_BEQ; aluop = ALU_SUB; extop = 1'b1; end
      OP_ADDI: begin cls = CLS_I;   aluop = ALU_ADD; extop = 1'b1; end
      OP_ANDI: begin cls = CLS_I;   aluop = ALU_AND; extop = 1'b0; end
      OP_ORI:  begin cls = CLS_I;   aluop = ALU_OR;  extop = 1'b0; end
      OP_J:    cls = CLS_J;
      default: cls = CLS_ILL;
    endcase
  end

  assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FSM sequencer for the MIPS-subset datapath with memory req/ready stalls.
// Define MC_PERF_CNT_EN to add the cyc_cnt/instr_cnt/stall_cnt performance counters.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int ALU_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             regdst,
  output logic             regwrite,
  output logic             extop,
  output logic             alusrc,
  output logic [ALU_W-1:0] aluop,
  output logic             memwrite,
  output logic             mem2reg,
  output logic             trap,
  output logic [3:0]       state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (ALU_W < 4 || CNT_W < 1) begin : g_param_check
    $error("multicycle_ctrl: ALU_W must be >= 4 and CNT_W >= 1");
  end

  logic [3:0] state_q, state_d;
  mc_cls_e    cls_q, cls_d;
  logic [3:0] aluop_q, aluop_d;
  logic       extop_q, extop_d;

  mc_cls_e    dec_cls;
  logic [3:0] dec_aluop;
  logic       dec_extop;
  logic       dec_legal;
  logic [3:0] alu_int;

  mc_decode u_decode (
    .opcode (opcode),
    .func   (func),
    .cls    (dec_cls),
    .aluop  (dec_aluop),
    .extop  (dec_extop),
    .legal  (dec_legal)
  );

  // The IR may change once DECODE is left, so the decoded controls are latched here.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    aluop_d = aluop_q;
    extop_d = extop_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d   = dec_cls;
        aluop_d = dec_aluop;
        extop_d = dec_extop;
        if (!dec_legal) begin
          state_d = ST_TRAP;
        end else begin
          case (dec_cls)
            CLS_R:          state_d = ST_EXEC_R;
            CLS_I:          state_d = ST_EXEC_I;
            CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
            CLS_BEQ:        state_d = ST_BRANCH;
            CLS_J:          state_d = ST_JUMP;
            default:        state_d = ST_TRAP;
          endcase
        end
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_WB_R:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_WB_I:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (cls_q == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
      ST_WB_MEM:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CLS_ILL;
      aluop_q <= ALU_AND;
      extop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      aluop_q <= aluop_d;
      extop_q <= extop_d;
    end
  end

  // Outputs are qualified by rst_n so an in-flight request drops the moment reset asserts.
  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PCSRC_INC;
    regdst   = 1'b0;
    regwrite = 1'b0;
    extop    = 1'b0;
    alusrc   = 1'b0;
    alu_int  = ALU_AND;
    memwrite = 1'b0;
    mem2reg  = 1'b0;
    trap     = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PCSRC_INC;
          end
        end
        ST_EXEC_R: alu_int = aluop_q;
        ST_WB_R: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        ST_EXEC_I: begin
          alusrc  = 1'b1;
          alu_int = aluop_q;
          extop   = extop_q;
        end
        ST_WB_I:   regwrite = 1'b1;
        ST_MEM_ADDR: begin
          alusrc  = 1'b1;
          extop   = 1'b1;
          alu_int = ALU_ADD;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        ST_WB_MEM: begin
          mem2reg  = 1'b1;
          regwrite = 1'b1;
        end
        ST_MEM_WR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        ST_BRANCH: begin
          alu_int  = ALU_SUB;
          extop    = 1'b1;
          pc_src   = PCSRC_BR;
          pc_write = zero;
        end
        ST_JUMP: begin
          pc_src   = PCSRC_JMP;
          pc_write = 1'b1;
        end
        ST_TRAP:   trap = 1'b1;
        default:   trap = 1'b0;
      endcase
    end
  end

  assign aluop = ALU_W'(alu_int);
  assign state = state_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // An instruction retires on every transition back into FETCH.
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    instr_cnt_d = instr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q != ST_TRAP) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    if (state_d == ST_FETCH && state_q != ST_FETCH) instr_cnt_d = instr_cnt_q + CNT_W'(1);
    if (mem_req && !mem_ready) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
